// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants and types for the decode/writeback slice
package reg_file_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] RA_REG   = 5'd31;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: one combinational read port, $0 forced to zero, optional write bypass (REG_FILE_WRITE_BYPASS_EN)
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr_i,
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  output logic [DATA_W-1:0] data_o
);
`ifdef REG_FILE_WRITE_BYPASS_EN
  // $0 reads zero; a same-cycle write to the read address is forwarded
  always_comb
    data_o = (addr_i == '0) ? '0 : (wr_en_i && addr_i == wr_addr_i) ? wr_data_i : regs_i[addr_i];
`else
  // $0 reads zero; otherwise read the stored value
  always_comb
    data_o = (addr_i == '0) ? '0 : regs_i[addr_i];
`endif
endmodule

// File: rtl/reg_file.sv
// reg_file: MIPS 32-entry register file with write-event counter; REG_FILE_WRITE_BYPASS_EN enables read bypass
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  wr_count,
  output logic              wr_dropped
);
  localparam int N = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              commit;
  assign commit = wr_en && (wr_addr != '0);
  // next counter value and dropped-write pulse; gated by wr_en so X on wr_addr is harmless when idle
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(commit);
    drop_d = wr_en && (wr_addr == '0);
  end
  // storage, counter and drop flag with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (commit) regs_q[wr_addr] <= wr_data;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end
  assign wr_count   = cnt_q;
  assign wr_dropped = drop_q;
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs (
    .regs_i   (regs_q),
    .addr_i   (rs_addr),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
`endif
    .data_o   (rs_data)
  );
  reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt (
    .regs_i   (regs_q),
    .addr_i   (rt_addr),
`ifdef REG_FILE_WRITE_BYPASS_EN
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
`endif
    .data_o   (rt_data)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus randomized checks of reg_file against an array-based reference model
module tb_reg_file;
`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs_addr = '0, rt_addr = '0, wr_addr = '0;
  logic [31:0] rs_data, rt_data, wr_data = '0;
  logic wr_en = 1'b0, wr_dropped;
  logic [CW-1:0] wr_count;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem [32];
  int cnt = 0;
  bit drop = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_count(wr_count), .wr_dropped(wr_dropped)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    cnt = 0;
    drop = 0;
  endtask

  // one clock edge, with the model applying the architectural write rules
  task automatic cyc();
    @(posedge clk);
    if (rst) clr_model();
    else begin
      drop = wr_en && wr_addr == 0;
      if (wr_en && wr_addr != 0) begin
        mem[wr_addr] = wr_data;
        cnt = (cnt + 1) % (1 << CW);
      end
    end
    #1;
  endtask

  task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  initial begin
    clr_model();
    cyc(); cyc();
    rs_addr = 5;
    chk("reset_rd5", rs_data, 0);
    chk("reset_cnt", 32'(wr_count), 0);
    chk("reset_drop", 32'(wr_dropped), 0);
    rst = 1'b0;
    // basic write/read
    drv(1, 8, 32'h12345678); cyc(); drv(0, 0, 0);
    rs_addr = 8; rt_addr = 9; #1;
    chk("wr8_rs", rs_data, 32'h12345678);
    chk("wr8_rt9", rt_data, 0);
    chk("wr8_cnt", 32'(wr_count), 1);
    // write to $0 is dropped
    drv(1, 0, 32'hFFFFFFFF); cyc(); drv(0, 0, 0);
    rs_addr = 0; #1;
    chk("zero_rd", rs_data, 0);
    chk("zero_drop1", 32'(wr_dropped), 1);
    chk("zero_cnt", 32'(wr_count), 1);
    cyc();
    chk("zero_drop0", 32'(wr_dropped), 0);
    // same-cycle read/write
    drv(1, 3, 32'hA); cyc();
    drv(1, 3, 32'hB); rs_addr = 3; rt_addr = 3; #1;
    chk("rw_same_pre", rs_data, BYP ? 32'hB : 32'hA);
    chk("rw_same_ports", rt_data, rs_data);
    cyc(); drv(0, 0, 0); #1;
    chk("rw_same_post", rs_data, 32'hB);
    chk("rw_cnt", 32'(wr_count), 3);
    // wr_en low: no effect
    drv(0, 4, 32'h55); cyc(); drv(0, 0, 0);
    rs_addr = 4; #1;
    chk("noen_rd4", rs_data, 0);
    chk("noen_cnt", 32'(wr_count), 3);
    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      drv($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      rs_addr = 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      #1;
      chk("rand_rs", rs_data, ref_rd(rs_addr));
      chk("rand_rt", rt_data, ref_rd(rt_addr));
      cyc();
      chk("rand_cnt", 32'(wr_count), 32'(cnt));
      chk("rand_drop", 32'(wr_dropped), 32'(drop));
    end
    // asynchronous reset mid-cycle
    drv(1, 5, 32'hDEADBEEF); cyc(); drv(0, 0, 0);
    rs_addr = 5; #1;
    chk("pre_rst_rd5", rs_data, 32'hDEADBEEF);
    #1 rst = 1'b1; clr_model(); #1;
    chk("async_rd5", rs_data, 0);
    chk("async_cnt", 32'(wr_count), 0);
    chk("async_drop", 32'(wr_dropped), 0);
    drv(1, 7, 32'h77); cyc();
    drv(0, 0, 0); rst = 1'b0;
    rs_addr = 7; #1;
    chk("rst_write_lost", rs_data, 0);
    chk("rst_write_cnt", 32'(wr_count), 0);
    // counter wrap with 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drv(1, 31, 32'h1000 + i); cyc();
    end
    drv(0, 0, 0); rs_addr = 31; #1;
    chk("wrap_cnt", 32'(wr_count), 1);
    chk("wrap_rd31", rs_data, 32'h1010);
    chk("wrap_model", 32'(wr_count), 32'(cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- MIPS 32-entry general-purpose register file.
- Sits in decode/writeback: two combinational read ports feed the ID stage.
- The single synchronous write port consumes the destination register number from the write-destination (rt/rd) select, plus write data from writeback.
- Register $0 is hardwired to zero.
- Adds a write-event counter for bring-up/debug.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- CNT_W, 16, width of the write-event counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs_addr  input  ADDR_W  read port A address (instr[25:21]).
- rt_addr  input  ADDR_W  read port B address (instr[20:16]).
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wr_en  input  1  RegWrite from control, write strobe.
- wr_addr  input  ADDR_W  destination register (output of the rt/rd select).
- wr_data  input  DATA_W  writeback data.
- wr_count  output  CNT_W  number of committed writes since reset.
- wr_dropped  output  1  registered pulse: write to $0 attempted last cycle.

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous, active-high.
- While rst is high:
  - all 32 registers = 0.
  - wr_count = 0.
  - wr_dropped = 0.
  - writes are ignored.
- Deassertion of rst is sampled on the next rising edge; first write can commit on the first edge with rst low.
- Write: on rising clk, if wr_en=1 and wr_addr!=0, then regs[wr_addr] <= wr_data.
  - Latency: 1 cycle; new value is visible on read ports after the edge.
- Write to $0 (wr_en=1, wr_addr=0):
  - storage unchanged.
  - wr_dropped=1 for exactly the following cycle.
  - wr_count not incremented.
- wr_en=0: no state change; wr_addr and wr_data are don't-care (X-tolerant).
- Read: purely combinational from the current storage.
  - Address 0 always returns 0, regardless of the storage contents.
- rs_addr==rt_addr: both ports return identical data.
- Read/write same register in the same cycle (without the optional feature): read returns the OLD value until the edge.
- wr_count:
  - increments by 1 on every committed write (wr_en=1, wr_addr!=0).
  - wraps from 2**CNT_W-1 to 0, with no saturation and no flag.
- Reset asserted mid-cycle: storage clears immediately, independent of clk.
  - A write coincident with the reset edge is lost.
- No X propagation: reads of registers never written since reset return 0.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: each read port forwards wr_data combinationally when wr_en=1, wr_addr!=0 and the read address equals wr_addr.
  - Gives write-before-read in the same cycle, so a WB/ID hazard needs no extra forwarding.
  - Address 0 still reads 0.
- Undefined: no bypass; read-old-value semantics as above.

Decomposition:
- Shared package reg_file_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - ZERO_REG=5'd0, RA_REG=5'd31.
  - typedef reg_addr_t = logic [4:0].
  - typedef reg_data_t = logic [31:0].
- RegDst select, control and ALU blocks use the same package constants.
- One sub-module, reg_read_port, instantiated twice. It contains:
  - address decode from storage.
  - the zero-register force.
  - the bypass compare/mux when REG_FILE_WRITE_BYPASS_EN is defined.
- Storage array and wr_count live in the top level.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing regs[5]=0xDEADBEEF.
  - rs_addr=5 reads 0 immediately, without waiting for a clk edge.
  - wr_count=0, wr_dropped=0.
- Basic write/read: write 0x12345678 to $8 (wr_en=1, wr_addr=8).
  - Next cycle rs_addr=8 gives 0x12345678; rt_addr=9 gives 0.
  - wr_count=1.
- Zero register: write 0xFFFFFFFF to $0.
  - rs_addr=0 gives 0.
  - wr_dropped=1 for one cycle, then 0.
  - wr_count unchanged.
- Same-cycle read/write: $3 holds 0xA; write 0xB to $3 while rs_addr=3.
  - Without macro: 0xA before the edge.
  - With REG_FILE_WRITE_BYPASS_EN: 0xB.
  - Both cases: 0xB after the edge.
- wr_en low: wr_en=0, wr_addr=4, wr_data=0x55.
  - $4 remains 0; wr_count unchanged.
- Counter wrap: with CNT_W=4, perform 17 writes to $31.
  - wr_count reads 1.
  - $31 holds the last data written.
